unified_memory_arbiter: RTL and testbench
=========================================

Name: unified_memory_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF port) and data load/store (MEM port) of the 5-stage pipeline.
- Sequences each access through a small FSM: arbitrate, issue, wait for memory ready, return data.
- Generates per-port stall signals that feed the hazard unit.
- Anti-starvation counter guarantees fetch progress under back-to-back data traffic.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive MEM grants with IF pending before IF is forced to win (legal range 1..15)
TIMEOUT_CYCLES, 16, BUSY-state watchdog limit (used only with optional feature)

Ports:
ClockSource  in  1  single clock, all state on posedge
ResetN  in  1  asynchronous active-low reset
IF_Req  in  1  fetch request, held high until IF_Valid
IF_Address  in  ADDR_W  fetch address
IF_ReadData  out  DATA_W  fetched word, registered
IF_Valid  out  1  one-cycle completion pulse for IF
MEM_Req  in  1  data request, held high until MEM_Valid
MEM_Write  in  1  1=store, 0=load
MEM_Address  in  ADDR_W  data address
MEM_WriteData  in  DATA_W  store data
MEM_ReadData  out  DATA_W  load data, registered
MEM_Valid  out  1  one-cycle completion pulse for MEM
Mem_Enable  out  1  one-cycle access strobe to memory
Mem_WriteEnable  out  1  write qualifier, valid with Mem_Enable
Mem_Address  out  ADDR_W  latched access address
Mem_WriteData  out  DATA_W  latched store data
Mem_ReadData  in  DATA_W  memory read data, valid with Mem_Ready
Mem_Ready  in  1  memory completion
StallIF  out  1  IF_Req & ~IF_Valid (combinational)
StallMEM  out  1  MEM_Req & ~MEM_Valid (combinational)
MemError  out  1  sticky timeout flag (optional feature)

Behaviour:
- Reset (ResetN low, async): state=IDLE; all registered outputs 0; starve counter 0; MemError 0; an in-flight access is abandoned and no Valid is issued.
- States: IDLE, BUSY, DONE.
- IDLE arbitration at posedge:
  - MEM_Req only -> grant MEM.
  - IF_Req only -> grant IF.
  - Both requesting -> MEM wins, unless starve counter == STARVE_LIMIT, in which case IF wins.
  - Neither -> stay IDLE.
  - On a grant: latch owner, address, write flag and write data; go to BUSY.
- BUSY:
  - Mem_Enable=1 in the first BUSY cycle only.
  - Mem_Address, Mem_WriteData and Mem_WriteEnable (=MEM_Write & owner==MEM) hold for the whole of BUSY.
  - Requester input changes during BUSY are ignored.
  - At the posedge with Mem_Ready=1: capture Mem_ReadData into the owner's ReadData register; go to DONE.
- DONE (one cycle): owner's Valid=1; the other port's ReadData is unchanged; next state IDLE. Requester drops Req in this cycle or earlier.
- Minimum latency is 3 cycles from request sampled to Valid (Mem_Ready high in the first BUSY cycle).
- Stores: MEM_Valid pulses as the write acknowledge; MEM_ReadData is unchanged on stores.
- Starve counter:
  - +1 on each MEM grant while IF_Req is high.
  - Cleared on each IF grant.
  - Saturates at STARVE_LIMIT.
- Mem_Ready outside BUSY is ignored.
- Mem_Enable is never high in IDLE or DONE.
- Only one access is outstanding at any time.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts BUSY cycles.
  - If Mem_Ready is not seen within TIMEOUT_CYCLES cycles, go to DONE with the owner's ReadData=0 and Valid pulsed.
  - MemError is set and stays set until reset.
- Undefined:
  - BUSY waits indefinitely.
  - MemError is tied 0.
  - No watchdog logic is present.

Test Plan:
- IF_Req=1, IF_Address=0x10, memory returns 0xDEADBEEF with Mem_Ready in the first BUSY cycle -> Mem_Enable one cycle with Mem_Address=0x10; IF_Valid on cycle 3; IF_ReadData=0xDEADBEEF; StallIF high for cycles 1-2.
- IF_Req and MEM_Req (load 0x40) raised in the same cycle -> MEM served first; IF is granted in the IDLE cycle after MEM's DONE; StallIF is held throughout.
- IF_Req held high, MEM_Req reissued back-to-back 6 times, STARVE_LIMIT=4 -> IF is granted after the 4th MEM grant; counter clears; MEM resumes afterwards.
- Store MEM_Write=1, address 0x80, data 0x1234 -> Mem_WriteEnable=1, Mem_WriteData=0x1234 held through BUSY; MEM_Valid pulses; MEM_ReadData is unchanged.
- ResetN pulled low mid-BUSY -> Mem_Enable, Valids and state are cleared immediately; no Valid is issued after release; a new request is served normally.
- With MEM_ARB_TIMEOUT_EN and Mem_Ready held 0 -> Valid pulses after 16 BUSY cycles with ReadData=0; MemError=1 and stays set until reset.

Source files
------------

// File: rtl/unified_memory_arbiter.sv
// unified_memory_arbiter: shares one single-port memory between the instruction
// fetch (IF) port and the data load/store (MEM) port of a 5-stage pipeline.
// Each access runs IDLE -> BUSY -> DONE. MEM has priority, but an anti-starvation
// counter forces IF to win once MEM has taken STARVE_LIMIT grants while IF waited.
// Optional feature macro: MEM_ARB_TIMEOUT_EN adds a BUSY-state watchdog that
// completes a hung access with zero data and sets the sticky MemError flag.
//
// Handshake: a requester raises Req with its address/data and holds Req high
// until it sees its one-cycle Valid pulse. It drops Req in the Valid (DONE)
// cycle or earlier. Inputs are only sampled in IDLE; changes while the access
// is in flight have no effect. Toward memory, Mem_Enable is a one-cycle strobe
// in the first BUSY cycle; the memory answers with Mem_Ready (and read data) in
// any BUSY cycle, and Mem_Ready seen outside BUSY is ignored.
module unified_memory_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              ClockSource,
  input  logic              ResetN,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Address,
  output logic [DATA_W-1:0] IF_ReadData,
  output logic              IF_Valid,
  input  logic              MEM_Req,
  input  logic              MEM_Write,
  input  logic [ADDR_W-1:0] MEM_Address,
  input  logic [DATA_W-1:0] MEM_WriteData,
  output logic [DATA_W-1:0] MEM_ReadData,
  output logic              MEM_Valid,
  output logic              Mem_Enable,
  output logic              Mem_WriteEnable,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_WriteData,
  input  logic [DATA_W-1:0] Mem_ReadData,
  input  logic              Mem_Ready,
  output logic              StallIF,
  output logic              StallMEM,
  output logic              MemError,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [1:0]        state;
  logic              owner_mem;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              enable_q;
  logic [3:0]        starve_cnt;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_valid_q;
  logic              mem_valid_q;

  logic              grant_if;
  logic              timeout;
  logic              finish;
  logic [DATA_W-1:0] finish_data;

  // IF wins when it is alone, or when MEM has starved it for STARVE_LIMIT grants.
  assign grant_if    = IF_Req && (!MEM_Req || (starve_cnt == STARVE_MAX));
  assign finish      = (state == BUSY) && (Mem_Ready || timeout);
  assign finish_data = Mem_Ready ? Mem_ReadData : '0;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign timeout = (state == BUSY) && !Mem_Ready &&
                   (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts BUSY cycles, restarts on every new access, sticky error.
  always_ff @(posedge ClockSource or negedge ResetN) begin
    if (!ResetN) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state != BUSY) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + 1'b1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign MemError = err_q;
`else
  assign timeout  = 1'b0;
  assign MemError = 1'b0;
`endif

  // Access sequencer: arbitrate in IDLE, hold the access in BUSY, pulse Valid in DONE.
  always_ff @(posedge ClockSource or negedge ResetN) begin
    if (!ResetN) begin
      state       <= IDLE;
      owner_mem   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      enable_q    <= 1'b0;
      starve_cnt  <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
    end else begin
      enable_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (IF_Req || MEM_Req) begin
            state     <= BUSY;
            enable_q  <= 1'b1;
            owner_mem <= !grant_if;
            addr_q    <= grant_if ? IF_Address : MEM_Address;
            write_q   <= !grant_if && MEM_Write;
            wdata_q   <= MEM_WriteData;
            if (grant_if)
              starve_cnt <= '0;
            else if (IF_Req && (starve_cnt != STARVE_MAX))
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        BUSY: begin
          if (finish) begin
            state <= DONE;
            if (owner_mem) begin
              mem_valid_q <= 1'b1;
              // Stores acknowledge without disturbing the last load result.
              if (!write_q) mem_rdata_q <= finish_data;
            end else begin
              if_valid_q <= 1'b1;
              if_rdata_q <= finish_data;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Mem_Enable      = enable_q;
  assign Mem_WriteEnable = write_q && (state == BUSY);
  assign Mem_Address     = addr_q;
  assign Mem_WriteData   = wdata_q;
  assign IF_ReadData     = if_rdata_q;
  assign MEM_ReadData    = mem_rdata_q;
  assign IF_Valid        = if_valid_q;
  assign MEM_Valid       = mem_valid_q;
  assign StallIF         = IF_Req && !if_valid_q;
  assign StallMEM        = MEM_Req && !mem_valid_q;
  assign dbg_state       = state;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Bench for unified_memory_arbiter: directed scenarios followed by random
// traffic, all checked every cycle against an access-level reference model.
module tb_unified_memory_arbiter;
  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int STARVE_LIMIT   = 4;
  localparam int TIMEOUT_CYCLES = 16;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic              ClockSource = 1'b0;
  logic              ResetN;
  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Address;
  logic [DATA_W-1:0] IF_ReadData;
  logic              IF_Valid;
  logic              MEM_Req;
  logic              MEM_Write;
  logic [ADDR_W-1:0] MEM_Address;
  logic [DATA_W-1:0] MEM_WriteData;
  logic [DATA_W-1:0] MEM_ReadData;
  logic              MEM_Valid;
  logic              Mem_Enable;
  logic              Mem_WriteEnable;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_WriteData;
  logic [DATA_W-1:0] Mem_ReadData;
  logic              Mem_Ready;
  logic              StallIF;
  logic              StallMEM;
  logic              MemError;
  logic [1:0]        dbg_state;

  unified_memory_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .ClockSource(ClockSource), .ResetN(ResetN),
    .IF_Req(IF_Req), .IF_Address(IF_Address), .IF_ReadData(IF_ReadData), .IF_Valid(IF_Valid),
    .MEM_Req(MEM_Req), .MEM_Write(MEM_Write), .MEM_Address(MEM_Address),
    .MEM_WriteData(MEM_WriteData), .MEM_ReadData(MEM_ReadData), .MEM_Valid(MEM_Valid),
    .Mem_Enable(Mem_Enable), .Mem_WriteEnable(Mem_WriteEnable), .Mem_Address(Mem_Address),
    .Mem_WriteData(Mem_WriteData), .Mem_ReadData(Mem_ReadData), .Mem_Ready(Mem_Ready),
    .StallIF(StallIF), .StallMEM(StallMEM), .MemError(MemError), .dbg_state(dbg_state)
  );

  always #5 ClockSource = ~ClockSource;

  // ---------------- result bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------- memory responder ----------------
  int                rsp_delay = 0;      // -1: random 0..3 extra BUSY cycles
  bit                rsp_word_fixed = 1'b0;
  logic [DATA_W-1:0] rsp_word = '0;
  bit                rsp_hang = 1'b0;
  bit                rsp_junk = 1'b0;
  bit                rsp_pend = 1'b0;
  int                rsp_cnt = 0;
  logic [DATA_W-1:0] rsp_val = '0;

  // Answers each Mem_Enable strobe after the configured delay; optionally
  // toggles Mem_Ready while no access is pending to show it is ignored.
  always @(posedge ClockSource) begin
    #1;
    Mem_Ready    = 1'b0;
    Mem_ReadData = $urandom;
    if (!ResetN) rsp_pend = 1'b0;
    else if (Mem_Enable) begin
      rsp_pend = 1'b1;
      rsp_val  = rsp_word_fixed ? rsp_word : $urandom;
      if (rsp_hang)            rsp_cnt = 1 << 30;
      else if (rsp_delay < 0)  rsp_cnt = $urandom_range(0, 3);
      else                     rsp_cnt = rsp_delay;
    end
    if (rsp_pend) begin
      if (rsp_cnt == 0) begin
        Mem_Ready    = 1'b1;
        Mem_ReadData = rsp_val;
        rsp_pend     = 1'b0;
      end else rsp_cnt--;
    end else if (ResetN && rsp_junk && !Mem_Enable && $urandom_range(0, 3) == 0) begin
      Mem_Ready = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  logic [ADDR_W-1:0] exp_q[$];           // expected address of each memory strobe
  bit                m_busy = 1'b0;
  bit                m_done = 1'b0;
  bit                m_owner_mem = 1'b0;
  bit                m_we = 1'b0;
  int                m_age = 0;
  int                m_starve = 0;
  bit                m_if_wins;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  logic [DATA_W-1:0] m_data;
  logic              e_if_valid = 1'b0;
  logic              e_mem_valid = 1'b0;
  logic              e_en = 1'b0;
  logic              e_err = 1'b0;
  logic [DATA_W-1:0] e_if_rdata = '0;
  logic [DATA_W-1:0] e_mem_rdata = '0;

  // One access at a time: a grant, some busy cycles, a one-cycle completion.
  always @(posedge ClockSource or negedge ResetN) begin
    if (!ResetN) begin
      m_busy = 1'b0; m_done = 1'b0; m_starve = 0; m_age = 0;
      e_if_valid = 1'b0; e_mem_valid = 1'b0; e_en = 1'b0; e_err = 1'b0;
      e_if_rdata = '0; e_mem_rdata = '0;
      exp_q.delete();
    end else begin
      e_if_valid = 1'b0; e_mem_valid = 1'b0; e_en = 1'b0;
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_busy) begin
        m_age++;
        if (Mem_Ready || (TIMEOUT_EN && m_age >= TIMEOUT_CYCLES)) begin
          m_data = Mem_Ready ? Mem_ReadData : '0;
          if (!Mem_Ready) e_err = 1'b1;
          if (m_owner_mem) begin
            e_mem_valid = 1'b1;
            if (!m_we) e_mem_rdata = m_data;
          end else begin
            e_if_valid = 1'b1;
            e_if_rdata = m_data;
          end
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (IF_Req || MEM_Req) begin
        m_if_wins = IF_Req && (!MEM_Req || m_starve >= STARVE_LIMIT);
        if (m_if_wins) m_starve = 0;
        else if (IF_Req && m_starve < STARVE_LIMIT) m_starve++;
        m_owner_mem = !m_if_wins;
        m_addr      = m_if_wins ? IF_Address : MEM_Address;
        m_we        = !m_if_wins && MEM_Write;
        m_wdata     = MEM_WriteData;
        exp_q.push_back(m_addr);
        m_busy = 1'b1;
        m_age  = 0;
        e_en   = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge ClockSource) begin
    if (chk_on) begin
      chk("if_valid", IF_Valid, e_if_valid);
      chk("mem_valid", MEM_Valid, e_mem_valid);
      chk("if_rdata", IF_ReadData, e_if_rdata);
      chk("mem_rdata", MEM_ReadData, e_mem_rdata);
      chk("mem_enable", Mem_Enable, e_en);
      chk("stall_if", StallIF, IF_Req && !e_if_valid);
      chk("stall_mem", StallMEM, MEM_Req && !e_mem_valid);
      chk("mem_error", MemError, e_err);
      if (m_busy) begin
        chk("addr_hold", Mem_Address, m_addr);
        chk("we_hold", Mem_WriteEnable, m_we);
        if (m_we) chk("wdata_hold", Mem_WriteData, m_wdata);
      end
      if (Mem_Enable && ResetN) begin
        if (exp_q.size() == 0) note_fail("strobe_unexpected");
        else chk("strobe_addr", Mem_Address, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ClockSource);
    #1;
    if (IF_Valid)  IF_Req  = 1'b0;
    if (MEM_Valid) MEM_Req = 1'b0;
  endtask

  task automatic wait_valid(input bit want_mem, input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(want_mem ? MEM_Valid : IF_Valid) && n < limit);
    if (!(want_mem ? MEM_Valid : IF_Valid)) note_fail(want_mem ? "wait_mem_valid" : "wait_if_valid");
  endtask

  task automatic do_reset();
    ResetN  = 1'b0;
    IF_Req  = 1'b0;
    MEM_Req = 1'b0;
    repeat (3) @(posedge ClockSource);
    #1 ResetN = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, t_mem, t_if, mem_done, mem_issued, if_issued, if_cnt, at1, at2, if_age, mem_age;
    logic [DATA_W-1:0] saved;
    ResetN = 1'b0; IF_Req = 1'b0; IF_Address = '0; MEM_Req = 1'b0; MEM_Write = 1'b0;
    MEM_Address = '0; MEM_WriteData = '0; Mem_ReadData = '0; Mem_Ready = 1'b0;
    @(posedge ClockSource);
    chk_on = 1'b1;
    do_reset();
    chk("reset_if_rdata", IF_ReadData, 0);
    chk("reset_enable", Mem_Enable, 0);

    // Single fetch, memory ready in first BUSY cycle.
    rsp_delay = 0; rsp_word_fixed = 1'b1; rsp_word = 32'hDEADBEEF;
    IF_Req = 1'b1; IF_Address = 32'h10;
    #1 chk("d1_stall_c1", StallIF, 1);
    tick();
    chk("d1_enable", Mem_Enable, 1);
    chk("d1_addr", Mem_Address, 32'h10);
    chk("d1_stall_c2", StallIF, 1);
    tick();
    chk("d1_valid_c3", IF_Valid, 1);
    chk("d1_rdata", IF_ReadData, 32'hDEADBEEF);
    chk("d1_stall_c3", StallIF, 0);
    tick();
    rsp_word_fixed = 1'b0;

    // Simultaneous IF and MEM load: MEM first, IF in the IDLE after MEM's DONE.
    rsp_delay = 1;
    IF_Req = 1'b1; IF_Address = 32'h14;
    MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Address = 32'h40;
    t_mem = -1; t_if = -1;
    for (int t = 1; t <= 30 && t_if < 0; t++) begin
      tick();
      if (MEM_Valid) t_mem = t;
      if (IF_Valid) t_if = t;
      else chk("d2_stall_if", StallIF, 1);
    end
    chk("d2_mem_time", t_mem, 3);
    chk("d2_if_time", t_if, 7);
    tick();

    // IF held while MEM reissues 6 loads back to back.
    rsp_delay = 0;
    IF_Req = 1'b1; IF_Address = 32'h100;
    MEM_Req = 1'b1; MEM_Address = 32'h200;
    mem_issued = 1; if_issued = 1; mem_done = 0; if_cnt = 0; at1 = -1; at2 = -1;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (MEM_Valid) mem_done++;
      if (IF_Valid) begin
        if_cnt++;
        if (if_cnt == 1) at1 = mem_done; else at2 = mem_done;
      end
      if (!MEM_Req && !MEM_Valid && mem_issued < 6) begin
        MEM_Req = 1'b1; MEM_Address = 32'h200 + 32'(mem_issued * 4); mem_issued++;
      end
      if (!IF_Req && !IF_Valid && if_issued < 2) begin
        IF_Req = 1'b1; IF_Address = 32'h104; if_issued++;
      end
      if (mem_done == 6 && if_cnt == 2) break;
    end
    chk("d3_mem_before_if", at1, 4);
    chk("d3_mem_before_if2", at2, 6);
    tick();

    // Store: write qualifier and data held, load result untouched.
    rsp_delay = 2;
    saved = e_mem_rdata;
    MEM_Req = 1'b1; MEM_Write = 1'b1; MEM_Address = 32'h80; MEM_WriteData = 32'h1234;
    for (int b = 0; b < 3; b++) begin
      tick();
      chk("d4_we", Mem_WriteEnable, 1);
      chk("d4_wdata", Mem_WriteData, 32'h1234);
      chk("d4_addr", Mem_Address, 32'h80);
      MEM_Address = 32'hFFF0; MEM_WriteData = 32'hBAD; MEM_Write = 1'b0;
    end
    tick();
    chk("d4_valid", MEM_Valid, 1);
    chk("d4_rdata_kept", MEM_ReadData, saved);
    tick();

    // Reset in the middle of BUSY abandons the access.
    rsp_delay = 3;
    IF_Req = 1'b1; IF_Address = 32'h30;
    tick();
    ResetN = 1'b0; IF_Req = 1'b0;
    #1;
    chk("d5_enable_cleared", Mem_Enable, 0);
    chk("d5_valid_cleared", IF_Valid, 0);
    repeat (2) @(posedge ClockSource);
    #1 ResetN = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      chk("d5_no_valid", IF_Valid, 0);
    end
    rsp_delay = 0; rsp_word_fixed = 1'b1; rsp_word = 32'hCAFEF00D;
    IF_Req = 1'b1; IF_Address = 32'h20;
    wait_valid(1'b0, 20, n);
    chk("d5_latency", n, 2);
    chk("d5_rdata", IF_ReadData, 32'hCAFEF00D);
    rsp_word_fixed = 1'b0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: watchdog completes the fetch with zero data.
    rsp_hang = 1'b1;
    IF_Req = 1'b1; IF_Address = 32'h44;
    wait_valid(1'b0, 40, n);
    chk("to_latency", n, 1 + TIMEOUT_CYCLES);
    chk("to_rdata", IF_ReadData, 0);
    chk("to_err", MemError, 1);
    rsp_hang = 1'b0;
    tick();
    MEM_Req = 1'b1; MEM_Write = 1'b0; MEM_Address = 32'h48;
    wait_valid(1'b1, 20, n);
    chk("to_err_sticky", MemError, 1);
    tick();
    do_reset();
    chk("to_err_reset", MemError, 0);
`endif

    // Random traffic with random memory latency and stray Mem_Ready pulses.
    rsp_delay = -1; rsp_junk = 1'b1;
    if_age = 0; mem_age = 0;
    for (int t = 0; t < 2500; t++) begin
      tick();
      if (!IF_Req && !IF_Valid && $urandom_range(0, 2) == 0) begin
        IF_Req = 1'b1; IF_Address = $urandom; if_age = 0;
      end
      if (!MEM_Req && !MEM_Valid && $urandom_range(0, 1) == 0) begin
        MEM_Req = 1'b1; MEM_Write = 1'($urandom_range(0, 1));
        MEM_Address = $urandom; MEM_WriteData = $urandom; mem_age = 0;
      end
      if (IF_Req && $urandom_range(0, 7) == 0) IF_Address = $urandom;
      if (MEM_Req && $urandom_range(0, 7) == 0) MEM_WriteData = $urandom;
      if (IF_Req) if_age++;
      if (MEM_Req) mem_age++;
      if (if_age > 150 || mem_age > 150) begin
        note_fail("random_progress");
        break;
      end
    end
    IF_Req = 1'b0; MEM_Req = 1'b0;
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
